// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B status LED blocks: status codes, GRB
// word layout and the status-to-colour map.
package ws2812b_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned G_LSB = 16;
  localparam int unsigned R_LSB = 8;
  localparam int unsigned B_LSB = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_OK    = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_LATCH  = 2'd1,
    S_STREAM = 2'd2
  } pix_state_e;

  function automatic logic [PIX_W-1:0] status_colour(
    input logic [1:0] status,
    input logic [7:0] level,
    input logic [7:0] frame_cnt,
    input logic [7:0] max_level
  );
    logic [PIX_W-1:0] c;
    c = '0;
    case (status)
      ST_IDLE:  c[B_LSB +: 8] = max_level >> 2;
      ST_BUSY:  c[B_LSB +: 8] = level;
      ST_OK:    c[G_LSB +: 8] = max_level;
      default:  c[R_LSB +: 8] = frame_cnt[4] ? 8'h00 : max_level;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ws2812b_frame_tick.sv
// Free-running frame-rate divider: one-cycle tick every CLK_HZ/FRAME_HZ clocks.
module ws2812b_frame_tick #(
  parameter int unsigned CLK_HZ   = 27000000,
  parameter int unsigned FRAME_HZ = 50
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned FRAME_DIV = CLK_HZ / FRAME_HZ;
  localparam int unsigned CNT_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/ws2812b_status_pixgen.sv
// Status-driven pixel source: animates a GRB colour from the bootloader status
// and streams NUM_LEDS copies of it per frame over valid/ready.
module ws2812b_status_pixgen
  import ws2812b_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 27000000,
  parameter int unsigned FRAME_HZ    = 50,
  parameter int unsigned NUM_LEDS    = 1,
  parameter logic [7:0]  MAX_LEVEL   = 8'h20,
  parameter int unsigned BREATH_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       status,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             overrun
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [7:0] STEP8    = 8'(BREATH_STEP);
  localparam logic [8:0] STEP9    = 9'(BREATH_STEP);

  pix_state_e state;
  logic       tick;
  logic [7:0] level, level_next;
  logic       dir_down, dir_next;
  logic [7:0] frame_cnt;
  logic [7:0] idx;
  logic [1:0] status_q;
  logic [8:0] up_sum;

  ws2812b_frame_tick #(
    .CLK_HZ  (CLK_HZ),
    .FRAME_HZ(FRAME_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign up_sum = {1'b0, level} + STEP9;

  // Breathing level: saturate at either bound and reverse there.
  always_comb begin
    level_next = level;
    dir_next   = dir_down;
    if (status != ST_BUSY) begin
      level_next = '0;
      dir_next   = 1'b0;
    end else if (!dir_down) begin
      if (up_sum >= {1'b0, MAX_LEVEL}) begin
        level_next = MAX_LEVEL;
        dir_next   = 1'b1;
      end else begin
        level_next = up_sum[7:0];
      end
    end else begin
      if ({1'b0, level} <= STEP9) begin
        level_next = '0;
        dir_next   = 1'b0;
      end else begin
        level_next = level - STEP8;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      level     <= '0;
      dir_down  <= 1'b0;
      frame_cnt <= '0;
      idx       <= '0;
      status_q  <= ST_IDLE;
      pix_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (tick) begin
        frame_cnt <= frame_cnt + 8'd1;
        level     <= level_next;
        dir_down  <= dir_next;
        // LATCH follows the tick by one cycle, so keep the status seen at the tick.
        status_q  <= status;
        if (state != S_WAIT) overrun <= 1'b1;
      end
      case (state)
        S_WAIT: begin
          if (tick && enable) state <= S_LATCH;
        end
        S_LATCH: begin
          pix_data <= status_colour(status_q, level, frame_cnt, MAX_LEVEL);
          idx      <= '0;
          state    <= S_STREAM;
        end
        S_STREAM: begin
          if (pix_ready) begin
            if (idx == LAST_IDX) state <= S_WAIT;
            else                 idx   <= idx + 8'd1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign pix_valid = (state == S_STREAM);
  assign pix_last  = pix_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_ws2812b_status_pixgen.sv
// Self-checking bench for ws2812b_status_pixgen (FRAME_DIV=10, NUM_LEDS=3, MAX_LEVEL=0x20).
module tb_ws2812b_status_pixgen;
  import ws2812b_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  status = 2'd0;
  logic        pix_ready = 1'b0;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_last;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ws2812b_status_pixgen #(
    .CLK_HZ     (1000),
    .FRAME_HZ   (100),
    .NUM_LEDS   (3),
    .MAX_LEVEL  (8'h20),
    .BREATH_STEP(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .status   (status),
    .pix_data (pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_last (pix_last),
    .overrun  (overrun)
  );

  // Reference: tick position, ticks since reset, consecutive BUSY ticks, status at last tick.
  int         m_cnt, m_frame, m_busy_run;
  logic [1:0] m_st;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_frame <= 0; m_busy_run <= 0; m_st <= ST_IDLE;
    end else begin
      m_cnt <= (m_cnt + 1) % 10;
      if (m_cnt == 9) begin
        m_frame    <= (m_frame + 1) % 256;
        m_busy_run <= (status == ST_BUSY) ? m_busy_run + 1 : 0;
        m_st       <= status;
      end
    end
  end

  // Triangle wave 0..32..0 with period 64 ticks.
  function automatic int tri_level(input int run);
    int p;
    p = run % 64;
    return (p <= 32) ? p : 64 - p;
  endfunction

  function automatic logic [23:0] exp_colour(input logic [1:0] st, input int run, input int frame);
    case (st)
      2'd0:    return 24'h000008;
      2'd1:    return {16'h0000, 8'(tri_level(run))};
      2'd2:    return 24'h200000;
      default: return (((frame / 16) % 2) == 0) ? 24'h002000 : 24'h000000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 40; i++) begin
      if (m_cnt == 9) break;
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b0; pix_ready = 1'b0; status = ST_IDLE;
    do_reset();
    n_checks++;
    if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
    n_checks++;
    if (pix_data !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 000000", pix_data); end
    n_checks++;
    if (pix_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", pix_last); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_ok_frame();
    int n;
    do_reset();
    status = ST_OK; enable = 1'b1; pix_ready = 1'b1;
    n = 0;
    while (pix_valid !== 1'b1 && n < 40) begin step(); n++; end
    n_checks++;
    if (n != 11) begin n_fail++; $display("FAIL ok_first_valid_latency: got %0d cycles expected 11", n); end
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== 24'h200000 || pix_last !== (w == 2)) begin
        n_fail++;
        $display("FAIL ok_word%0d: got valid=%b data=%h last=%b expected valid=1 data=200000 last=%b",
                 w, pix_valid, pix_data, pix_last, (w == 2));
      end
      step();
    end
    n_checks++;
    if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL ok_valid_drop: got %b expected 0", pix_valid); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ok_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_busy_breath();
    logic [7:0]  maxb;
    logic [23:0] exp;
    do_reset();
    status = ST_BUSY; enable = 1'b1; pix_ready = 1'b1;
    maxb = '0;
    for (int k = 1; k <= 70; k++) begin
      wait_tick();
      step();
      step();
      exp = {16'h0000, 8'(tri_level(k))};
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== exp) begin
        n_fail++;
        $display("FAIL busy_frame%0d: got valid=%b data=%h expected valid=1 data=%h", k, pix_valid, pix_data, exp);
      end
      if (pix_data[7:0] > maxb) maxb = pix_data[7:0];
    end
    n_checks++;
    if (maxb > 8'h20) begin n_fail++; $display("FAIL busy_peak: got %h expected <= 20", maxb); end
  endtask

  task automatic test_error_blink();
    logic [23:0] exp;
    do_reset();
    status = ST_ERROR; enable = 1'b1; pix_ready = 1'b1;
    for (int j = 1; j <= 64; j++) begin
      wait_tick();
      step();
      step();
      exp = (((j >> 4) & 1) == 0) ? 24'h002000 : 24'h000000;
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== exp) begin
        n_fail++;
        $display("FAIL error_frame%0d: got valid=%b data=%h expected valid=1 data=%h", j, pix_valid, pix_data, exp);
      end
    end
  endtask

  task automatic test_stall_overrun();
    logic [23:0] exp;
    do_reset();
    status = 2'($urandom_range(0, 3)); enable = 1'b1; pix_ready = 1'b0;
    wait_tick();
    step();
    exp = exp_colour(m_st, m_busy_run, m_frame);
    step();
    n_checks++;
    if (pix_valid !== 1'b1 || pix_data !== exp || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_first: got valid=%b data=%h overrun=%b expected 1 %h 0", pix_valid, pix_data, overrun, exp);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      if (i % 4 == 1) status = 2'($urandom_range(0, 3));
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== exp || pix_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got valid=%b data=%h last=%b expected 1 %h 0", i, pix_valid, pix_data, pix_last, exp);
      end
    end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL stall_overrun_set: got %b expected 1", overrun); end
    pix_ready = 1'b1;
    step();
    n_checks++;
    if (pix_valid !== 1'b1 || pix_last !== 1'b0) begin
      n_fail++; $display("FAIL stall_word1: got valid=%b last=%b expected 1 0", pix_valid, pix_last);
    end
    step();
    n_checks++;
    if (pix_last !== 1'b1 || pix_data !== exp) begin
      n_fail++; $display("FAIL stall_word2: got last=%b data=%h expected 1 %h", pix_last, pix_data, exp);
    end
    step();
    n_checks++;
    if (pix_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL stall_end: got valid=%b overrun=%b expected 0 1", pix_valid, overrun);
    end
  endtask

  task automatic test_tick_on_last();
    int bad;
    do_reset();
    status = ST_OK; enable = 1'b1; pix_ready = 1'b0;
    wait_tick();
    repeat (8) step();
    pix_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (pix_valid !== 1'b1 || pix_last !== 1'b1) begin
      n_fail++; $display("FAIL tol_last_at_tick: got valid=%b last=%b expected 1 1", pix_valid, pix_last);
    end
    step();
    n_checks++;
    if (pix_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL tol_after_last: got valid=%b overrun=%b expected 0 1", pix_valid, overrun);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pix_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL tol_no_restart: got %0d valid cycles expected 0", bad); end
    step();
    n_checks++;
    if (pix_valid !== 1'b1 || pix_data !== 24'h200000) begin
      n_fail++; $display("FAIL tol_next_frame: got valid=%b data=%h expected 1 200000", pix_valid, pix_data);
    end
    repeat (3) step();
  endtask

  task automatic test_status_midframe();
    int bad;
    do_reset();
    status = ST_IDLE; enable = 1'b1; pix_ready = 1'b0;
    wait_tick();
    step();
    step();
    status = ST_OK; enable = 1'b0;
    step();
    pix_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== 24'h000008 || pix_last !== (w == 2)) begin
        n_fail++;
        $display("FAIL mid_word%0d: got valid=%b data=%h last=%b expected 1 000008 %b",
                 w, pix_valid, pix_data, pix_last, (w == 2));
      end
      step();
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (pix_valid !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL mid_no_new_frame: got %0d valid cycles expected 0", bad); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    status = ST_OK; enable = 1'b1; pix_ready = 1'b0;
    wait_tick();
    repeat (12) step();
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL rstmid_overrun_pre: got %b expected 1", overrun); end
    pix_ready = 1'b1;
    step();
    n_checks++;
    if (pix_valid !== 1'b1 || pix_last !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idx1: got valid=%b last=%b expected 1 0", pix_valid, pix_last);
    end
    pix_ready = 1'b0;
    rst = 1'b1;
    step();
    n_checks++;
    if (pix_valid !== 1'b0 || pix_data !== 24'h0 || overrun !== 1'b0 || pix_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got valid=%b data=%h overrun=%b last=%b expected 0 000000 0 0",
               pix_valid, pix_data, overrun, pix_last);
    end
    rst = 1'b0;
    pix_ready = 1'b1;
    wait_tick();
    step();
    step();
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (pix_valid !== 1'b1 || pix_data !== 24'h200000 || pix_last !== (w == 2)) begin
        n_fail++;
        $display("FAIL rstmid_restart_word%0d: got valid=%b data=%h last=%b expected 1 200000 %b",
                 w, pix_valid, pix_data, pix_last, (w == 2));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp;
    enable = 1'b1; pix_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      status = 2'($urandom_range(0, 3));
      wait_tick();
      step();
      exp = exp_colour(m_st, m_busy_run, m_frame);
      step();
      for (int w = 0; w < 3; w++) begin
        n_checks++;
        if (pix_valid !== 1'b1 || pix_data !== exp || pix_last !== (w == 2)) begin
          n_fail++;
          $display("FAIL b2b_f%0d_w%0d: got valid=%b data=%h last=%b expected 1 %h %b",
                   f, w, pix_valid, pix_data, pix_last, exp, (w == 2));
        end
        if (w == 0) status = 2'($urandom_range(0, 3));
        step();
      end
      n_checks++;
      if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_f%0d_drop: got %b expected 0", f, pix_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_ok_frame();
    test_busy_breath();
    test_error_blink();
    test_stall_overrun();
    test_tick_on_last();
    test_status_midframe();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ws2812b_status_pixgen.md
Name: ws2812b_status_pixgen

Overview:
Upstream pixel source for the WS2812B serializer. It turns the bootloader status code into an animated GRB colour and streams one 24-bit word per LED, NUM_LEDS words per frame, over a valid/ready handshake. Frames start on an internal frame-rate tick. The downstream serializer owns bit timing and the >50 us latch gap that follows pix_last.

Parameters:
CLK_HZ, 27000000, input clock frequency in Hz
FRAME_HZ, 50, animation and frame rate; FRAME_DIV = CLK_HZ/FRAME_HZ (integer division)
NUM_LEDS, 1, pixels per frame (1..256)
MAX_LEVEL, 8'h20, peak channel intensity
BREATH_STEP, 1, level change per frame while breathing

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  permits new frames to start
status  in  2  0=IDLE 1=BUSY 2=OK 3=ERROR
pix_data  out  24  GRB word, G in [23:16], R in [15:8], B in [7:0]
pix_valid  out  1  pix_data is valid
pix_ready  in  1  downstream accepts the word
pix_last  out  1  current word is the frame's final pixel
overrun  out  1  sticky: a tick arrived while a frame was streaming

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets the following. It has priority over everything and aborts a frame mid-stream.
  - Outputs: pix_data=0, pix_valid=0, pix_last=0, overrun=0.
  - Internal: state=WAIT, tick counter=0, level=0, dir=up, frame_cnt=0, idx=0.
- Tick counter: counts 0..FRAME_DIV-1 and wraps. tick=1 for the single cycle when count==FRAME_DIV-1. It runs regardless of enable or state.
- Animation runs on every tick, in every state:
  - frame_cnt (8 bit) increments and wraps 255->0.
  - If status==BUSY: level moves by BREATH_STEP in direction dir and saturates at MAX_LEVEL or 0. When it reaches a bound, dir flips.
  - If status!=BUSY: level=0 and dir=up.
- Colour map, evaluated in LATCH:
  - IDLE: B = MAX_LEVEL>>2.
  - BUSY: B = level.
  - OK: G = MAX_LEVEL.
  - ERROR: R = MAX_LEVEL when frame_cnt[4]=0, else 0 (blink period 32 frames).
  - All other channels are 0.
- States:
  - WAIT: if tick && enable, go to LATCH.
  - LATCH (1 cycle): register the colour word into pix_data, set idx=0, go to STREAM.
  - STREAM:
    - pix_valid=1; pix_last = (idx==NUM_LEDS-1).
    - On pix_valid && pix_ready: if pix_last, go to WAIT and drop pix_valid the next cycle; otherwise idx++.
    - pix_data is held constant for the whole frame.
- Latency: tick in cycle T gives LATCH in T+1 and pix_valid=1 in T+2. The colour uses status as sampled at tick T, with animation values already updated by that tick.
- Handshake rules:
  - pix_data and pix_last are stable while pix_valid && !pix_ready.
  - pix_valid is never withdrawn before acceptance.
  - Back-to-back acceptance gives one pixel per cycle.
- Boundaries:
  - Tick while in STREAM or LATCH: overrun is set sticky until rst. No frame is queued, but the animation still advances.
  - enable falling mid-frame: the current frame completes; no new frame starts.
  - status change mid-frame: no effect until the next LATCH.
  - NUM_LEDS=1: pix_last=1 together with the first valid.
  - Tick in the same cycle the last pixel is accepted: counts as an overrun, and the frame is not restarted.

Decomposition:
- Shared package ws2812b_pkg holds:
  - status code constants ST_IDLE/ST_BUSY/ST_OK/ST_ERROR;
  - the GRB field offsets;
  - the pixel word width of 24.
- Natural sub-module: ws2812b_frame_tick, holding the divider and tick output, so other LED blocks can reuse it.
- The colour map is a function in the package.

Test Plan:
All scenarios use CLK_HZ=1000, FRAME_HZ=100 (FRAME_DIV=10), NUM_LEDS=3, MAX_LEVEL=8'h20.
- Reset then status=OK, enable=1, pix_ready=1: first pix_valid 2 cycles after the first tick. Three words 24'h200000; pix_last only on the third; pix_valid low the next cycle.
- BUSY over 70 ticks, BREATH_STEP=1: B sequence 1,2,...,32,31,...,0,1 across frames; never exceeds 8'h20.
- ERROR over 64 frames: R=8'h20 for frames with frame_cnt[4]=0, 24'h000000 otherwise; G=B=0 throughout.
- pix_ready held low for 15 cycles during a frame: pix_data and pix_valid stable, the tick falls inside the stall, overrun=1 and stays 1 until rst.
- Switch status IDLE->OK mid-frame, then drop enable: the frame finishes with 24'h000008 words and no further frames start.
- Assert rst during STREAM with idx=1: next cycle pix_valid=0, pix_data=0, overrun=0, and the next frame starts at idx=0.
